// File: rtl/audio_sample_fifo_if.sv
// audio_sample_fifo_if: picosoc iomem bus bundle between the CPU (master)
// and the audio sample FIFO (slave).
//   iomem_valid  master -> slave  bus request
//   iomem_ready  slave  -> master one-cycle acknowledge
//   iomem_wstrb  master -> slave  byte strobes, nonzero = write
//   iomem_addr   master -> slave  byte address
//   iomem_wdata  master -> slave  write data
//   iomem_rdata  slave  -> master registered read data
interface audio_sample_fifo_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: CPU-to-DAC stereo sample buffer on the picosoc iomem bus.
// Firmware pushes stereo words; one pair is popped per DACLRC rising edge and
// presented to i2s_tx.
//   clk           system clock
//   reset         synchronous, active-high
//   bus           iomem slave port (valid/ready/wstrb/addr/wdata/rdata)
//   lrclk         raw DACLRC pin, asynchronous
//   left_chan     left sample to i2s_tx
//   right_chan    right sample to i2s_tx
//   irq_lowwater  registered refill request: enable & level < DEPTH/2
// Registers (addr[3:2]): 0 DATA (W push), 1 STATUS (R, W1C bits 18/19),
//   2 CTRL ([0] enable, [1] flush self-clearing), 3 reserved.
module audio_sample_fifo #(
  parameter int          BITSIZE    = 16,
  parameter int          DEPTH_LOG2 = 6,
  parameter logic [7:0]  BASE_ADDR  = 8'h05
) (
  input  logic               clk,
  input  logic               reset,
  audio_sample_fifo_if.slave bus,
  input  logic               lrclk,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               irq_lowwater
);

  localparam int unsigned           DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   HALF_LVL = FULL_LVL >> 1;

  logic [2*BITSIZE-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   level, level_next;
  logic                  s1, s2, s3;
  logic                  enable, underrun, overflow;

  logic        hit, is_wr;
  logic [1:0]  sel;
  logic        push_req, status_wr, ctrl_wr, flush;
  logic        empty, full, pop_evt, pop_do, push_do;
  logic        underrun_evt, overflow_evt;
  logic [31:0] status_word, read_val;

  always_comb begin
    hit       = bus.iomem_valid & ~bus.iomem_ready & (bus.iomem_addr[31:24] == BASE_ADDR);
    is_wr     = |bus.iomem_wstrb;
    sel       = bus.iomem_addr[3:2];
    push_req  = hit & is_wr & (sel == 2'd0);
    status_wr = hit & is_wr & (sel == 2'd1);
    ctrl_wr   = hit & is_wr & (sel == 2'd2);
    flush     = ctrl_wr & bus.iomem_wdata[1];

    empty   = (level == '0);
    full    = (level == FULL_LVL);
    pop_evt = s2 & ~s3;
    // A pop coinciding with a flush sees the FIFO as already empty.
    pop_do       = pop_evt & enable & ~empty & ~flush;
    underrun_evt = pop_evt & enable & (empty | flush);
    // A pop in the same cycle frees the slot a full push needs.
    push_do      = push_req & (~full | pop_do);
    overflow_evt = push_req & full & ~pop_do;

    level_next = level;
    if (flush)
      level_next = '0;
    else if (push_do & ~pop_do)
      level_next = level + (DEPTH_LOG2+1)'(1);
    else if (pop_do & ~push_do)
      level_next = level - (DEPTH_LOG2+1)'(1);

    status_word                 = '0;
    status_word[DEPTH_LOG2:0]   = level;
    status_word[16]             = empty;
    status_word[17]             = full;
    status_word[18]             = underrun;
    status_word[19]             = overflow;

    case (sel)
      2'd1:    read_val = status_word;
      2'd2:    read_val = {31'b0, enable};
      default: read_val = '0;
    endcase
  end

  // Sample storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_do)
      mem[wptr] <= {bus.iomem_wdata[16 +: BITSIZE], bus.iomem_wdata[0 +: BITSIZE]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1              <= 1'b0;
      s2              <= 1'b0;
      s3              <= 1'b0;
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
      wptr            <= '0;
      rptr            <= '0;
      level           <= '0;
      enable          <= 1'b0;
      underrun        <= 1'b0;
      overflow        <= 1'b0;
      left_chan       <= '0;
      right_chan      <= '0;
      irq_lowwater    <= 1'b0;
    end else begin
      s1 <= lrclk;
      s2 <= s1;
      s3 <= s2;

      bus.iomem_ready <= hit;
      if (hit)
        bus.iomem_rdata <= read_val;

      if (flush)
        wptr <= '0;
      else if (push_do)
        wptr <= wptr + DEPTH_LOG2'(1);

      if (flush)
        rptr <= '0;
      else if (pop_do)
        rptr <= rptr + DEPTH_LOG2'(1);

      level <= level_next;

      if (ctrl_wr)
        enable <= bus.iomem_wdata[0];

      // A new event wins over a simultaneous W1C so it is never lost.
      if (underrun_evt)
        underrun <= 1'b1;
      else if (status_wr & bus.iomem_wdata[18])
        underrun <= 1'b0;

      if (overflow_evt)
        overflow <= 1'b1;
      else if (status_wr & bus.iomem_wdata[19])
        overflow <= 1'b0;

      if (!enable) begin
        left_chan  <= '0;
        right_chan <= '0;
      end else if (pop_evt) begin
        if (pop_do) begin
          left_chan  <= mem[rptr][2*BITSIZE-1:BITSIZE];
          right_chan <= mem[rptr][BITSIZE-1:0];
        end else begin
          left_chan  <= '0;
          right_chan <= '0;
        end
      end

      irq_lowwater <= enable & (level < HALF_LVL);
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: scoreboard bench for audio_sample_fifo with a
// queue-based reference model of the sample FIFO and its registers.
module tb_audio_sample_fifo;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lrclk = 1'b0;
  logic [15:0] left_chan, right_chan;
  logic irq_lowwater;

  always #5 clk = ~clk;

  audio_sample_fifo_if bus();

  audio_sample_fifo #(
    .BITSIZE    (16),
    .DEPTH_LOG2 (6),
    .BASE_ADDR  (8'h05)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .lrclk        (lrclk),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .irq_lowwater (irq_lowwater)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        is_read;
    logic [31:0] val;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] out_q[$];

  // Reference model
  logic [31:0] m_fifo[$];
  bit m_en, m_unf, m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int n;
    n = m_fifo.size();
    s = '0;
    s[6:0] = n[6:0];
    s[16]  = (n == 0);
    s[17]  = (n == 64);
    s[18]  = m_unf;
    s[19]  = m_ovf;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] rg);
    case (rg)
      2'd1:    return m_status();
      2'd2:    return {31'b0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_write(input logic [1:0] rg, input logic [31:0] wd);
    case (rg)
      2'd0: begin
        if (m_fifo.size() >= 64) m_ovf = 1'b1;
        else m_fifo.push_back(wd);
      end
      2'd1: begin
        if (wd[18]) m_unf = 1'b0;
        if (wd[19]) m_ovf = 1'b0;
      end
      2'd2: begin
        m_en = wd[0];
        if (wd[1]) m_fifo.delete();
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_pop();
    if (!m_en) return 32'h0;
    if (m_fifo.size() == 0) begin
      m_unf = 1'b1;
      return 32'h0;
    end
    return m_fifo.pop_front();
  endfunction

  function automatic void m_reset();
    m_fifo.delete();
    m_en  = 1'b0;
    m_unf = 1'b0;
    m_ovf = 1'b0;
  endfunction

  // Bus monitor: every acknowledge consumes one expected transaction.
  always @(negedge clk) begin
    bus_exp_t e;
    if (bus.iomem_ready) begin
      if (bus_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready=1 required no pending transaction at %0t", $time);
      end else begin
        e = bus_q.pop_front();
        if (e.is_read) check("rdata", bus.iomem_rdata, e.val);
      end
    end
  end

  // Output monitor: samples must be valid by the 4th clk edge after a rise.
  always @(posedge lrclk) begin
    logic [31:0] e;
    repeat (4) @(posedge clk);
    #1;
    if (out_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_pop: got lrclk rise required none pending at %0t", $time);
    end else begin
      e = out_q.pop_front();
      check("left_chan",  {16'h0, left_chan},  {16'h0, e[31:16]});
      check("right_chan", {16'h0, right_chan}, {16'h0, e[15:0]});
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // All bus tasks start #1 after a rising edge and end #1 after a rising edge.
  task automatic bus_drive(input logic [1:0] rg, input bit wr, input logic [31:0] wd,
                           input logic [31:0] exp_rd);
    bus_exp_t e;
    e.is_read = !wr;
    e.val     = exp_rd;
    bus_q.push_back(e);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = {8'h05, 20'h0, rg, 2'b00};
    bus.iomem_wstrb = wr ? 4'hf : 4'h0;
    bus.iomem_wdata = wd;
    @(posedge clk); #1;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic bus_xfer(input logic [1:0] rg, input bit wr, input logic [31:0] wd);
    logic [31:0] r;
    r = m_read(rg);
    if (wr) m_write(rg, wd);
    bus_drive(rg, wr, wd, r);
  endtask

  task automatic pop_evt();
    out_q.push_back(m_pop());
    @(negedge clk);
    lrclk = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    lrclk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Bus write landing on the same edge as the pop event.
  task automatic pop_with_write(input logic [1:0] rg, input logic [31:0] wd);
    logic [31:0] o;
    if (rg == 2'd0) begin
      o = m_pop();
      m_write(rg, wd);
    end else begin
      m_write(rg, wd);
      o = m_pop();
    end
    out_q.push_back(o);
    @(negedge clk);
    lrclk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus_drive(rg, 1'b1, wd, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    lrclk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_irq();
    check("irq_lowwater", {31'h0, irq_lowwater},
          {31'h0, (m_en && m_fifo.size() < 32)});
  endtask

  initial begin
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wdata = 32'h0;
    m_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'h0, bus.iomem_ready}, 32'h0);
    check("reset_rdata", bus.iomem_rdata, 32'h0);
    check("reset_left",  {16'h0, left_chan},  32'h0);
    check("reset_right", {16'h0, right_chan}, 32'h0);
    check("reset_irq",   {31'h0, irq_lowwater}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    bus_xfer(2'd1, 1'b0, 32'h0);

    // Single sample then underrun
    bus_xfer(2'd0, 1'b1, 32'h12345678);
    bus_xfer(2'd2, 1'b1, 32'h1);
    pop_evt();
    bus_xfer(2'd1, 1'b0, 32'h0);
    pop_evt();
    bus_xfer(2'd1, 1'b0, 32'h0);
    check_irq();
    bus_xfer(2'd1, 1'b1, 32'h00040000);
    bus_xfer(2'd1, 1'b0, 32'h0);

    // Overflow with enable off
    bus_xfer(2'd2, 1'b1, 32'h0);
    for (int i = 0; i < 65; i++) bus_xfer(2'd0, 1'b1, $urandom);
    bus_xfer(2'd1, 1'b0, 32'h0);
    bus_xfer(2'd1, 1'b1, 32'h00080000);
    bus_xfer(2'd1, 1'b0, 32'h0);
    pop_evt();
    bus_xfer(2'd1, 1'b0, 32'h0);
    check_irq();

    // Wrong base address: no acknowledge, no side effect
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h06000000;
    bus.iomem_wstrb = 4'hf;
    bus.iomem_wdata = 32'h0000_0003;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("miss_ready", {31'h0, bus.iomem_ready}, 32'h0);
    end
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus_xfer(2'd1, 1'b0, 32'h0);

    // Full FIFO: push coinciding with a pop is accepted
    bus_xfer(2'd2, 1'b1, 32'h1);
    pop_with_write(2'd0, $urandom);
    bus_xfer(2'd1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) pop_evt();

    // Flush after fill
    bus_xfer(2'd2, 1'b1, 32'h3);
    bus_xfer(2'd1, 1'b1, 32'h000C0000);
    for (int i = 0; i < 10; i++) bus_xfer(2'd0, 1'b1, $urandom);
    bus_xfer(2'd1, 1'b0, 32'h0);
    bus_xfer(2'd2, 1'b1, 32'h3);
    bus_xfer(2'd1, 1'b0, 32'h0);
    bus_xfer(2'd2, 1'b0, 32'h0);
    pop_evt();
    bus_xfer(2'd1, 1'b0, 32'h0);

    // Flush coinciding with a pop
    bus_xfer(2'd1, 1'b1, 32'h000C0000);
    for (int i = 0; i < 4; i++) bus_xfer(2'd0, 1'b1, $urandom);
    pop_with_write(2'd2, 32'h3);
    bus_xfer(2'd1, 1'b0, 32'h0);

    // Push into empty FIFO coinciding with a pop
    bus_xfer(2'd1, 1'b1, 32'h000C0000);
    pop_with_write(2'd0, $urandom);
    bus_xfer(2'd1, 1'b0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned op;
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2, 3: bus_xfer(2'd0, 1'b1, $urandom);
        4:  bus_xfer(2'd1, 1'b0, 32'h0);
        5, 6: pop_evt();
        7:  pop_with_write(2'd0, $urandom);
        8:  bus_xfer(2'd2, 1'b1, {30'h0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)});
        9:  bus_xfer(2'd1, 1'b1, $urandom);
        10: bus_xfer(2'($urandom_range(0, 3)), 1'b0, 32'h0);
        default: bus_xfer(2'd3, 1'b1, $urandom);
      endcase
      check_irq();
    end

    // Reset while an acknowledge is pending
    bus_xfer(2'd2, 1'b1, 32'h3);
    for (int i = 0; i < 5; i++) bus_xfer(2'd0, 1'b1, $urandom);
    begin
      bus_exp_t e;
      e.is_read = 1'b1;
      e.val     = m_read(2'd1);
      bus_q.push_back(e);
    end
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h05000004;
    bus.iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    bus.iomem_valid = 1'b0;
    check("pre_reset_ready", {31'h0, bus.iomem_ready}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    m_reset();
    check("midreset_ready", {31'h0, bus.iomem_ready}, 32'h0);
    check("midreset_rdata", bus.iomem_rdata, 32'h0);
    check("midreset_left",  {16'h0, left_chan}, 32'h0);
    check("midreset_irq",   {31'h0, irq_lowwater}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    bus_xfer(2'd1, 1'b0, 32'h0);
    bus_xfer(2'd2, 1'b0, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    check("bus_q_drained", bus_q.size(), 32'h0);
    check("out_q_drained", out_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
